// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the LFSR round-robin server: FSM
//                state type, LFSR width, safe seed, and the single definition
//                of the 8-bit Fibonacci feedback polynomial.
//  Contents    : state_t, LFSR_W, LFSR_SAFE_SEED, lfsr8_next, lfsr8_seed_fix
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // All-zero is the lock-up state of the LFSR, so it is never loaded.
    localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 8'h01;

    // One-hot server states.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SERVE = 4'b0010,
        ST_SEED  = 4'b0100,
        ST_HOLD  = 4'b1000
    } state_t;

    // One Fibonacci step: taps at bits 4,3,2,0, new bit shifted in at the MSB.
    function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] q);
        return {q[4] ^ q[3] ^ q[2] ^ q[0], q[LFSR_W-1:1]};
    endfunction

    // Replace a zero seed with the safe seed.
    function automatic logic [LFSR_W-1:0] lfsr8_seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_SAFE_SEED : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Searches the
//                request vector starting at ptr and wrapping modulo N, and
//                returns the first active requester as a one-hot vector plus
//                its binary index. The caller registers the outputs and owns
//                the pointer.
//  Ports       : req      [N-1:0]  in  - request vector
//                ptr      [IW-1:0] in  - highest-priority index
//                en                in  - arbitration enable (gates outputs)
//                gnt_next [N-1:0]  out - one-hot winner (0 if none / !en)
//                idx      [IW-1:0] out - binary index of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt_next,
    output logic [IW-1:0] idx
);

    int            w_pos;
    logic [IW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        gnt_next = '0;
        idx      = '0;
        w_found  = 1'b0;
        w_pos    = 0;
        w_sel    = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate position k steps after the pointer, wrapped into range.
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = IW'(w_pos);
            if (en && !w_found && req[w_sel]) begin
                w_found         = 1'b1;
                gnt_next[w_sel] = 1'b1;
                idx             = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_rr_server.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_rr_server
//  Description : Shares one 8-bit Fibonacci LFSR among NREQ requesters. Each
//                grant hands out the current LFSR word and advances the LFSR
//                by one step, so consumers see distinct words of one global
//                sequence. A one-hot FSM handles seeding and pausing; a
//                round-robin arbiter picks the requester.
//  Ports       : clk, rst_n (async, active-low)
//                req       [NREQ-1:0] in  - level requests
//                gnt       [NREQ-1:0] out - registered one-hot grant
//                rnd_data  [7:0]      out - random byte, valid while |gnt
//                seed_load            in  - strobe: load seed_val
//                seed_val  [7:0]      in  - new seed (0 replaced by 8'h01)
//                pause                in  - freeze grants and LFSR
//                grant_cnt [15:0]     out - wrapping grant counter
//                busy                 out - registered |gnt
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_rr_server
    import lfsr_pkg::*;
#(
    parameter int               NREQ = 4,
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] rnd_data,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              pause,
    output logic [15:0]       grant_cnt,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] C_LAST_IDX = PW'(NREQ - 1);

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] seed_q;      // seed captured at the strobe, applied in SEED
    logic [NREQ-1:0]   gnt_q;
    logic [LFSR_W-1:0] rnd_q;
    logic [15:0]       cnt_q;
    logic              busy_q;

    logic              w_grant_en;
    logic [NREQ-1:0]   w_gnt_next;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_ptr_d;

    // A grant happens only in SERVE and only when no higher-priority input
    // (seed_load, then pause) claims the cycle.
    assign w_grant_en = (state_q == ST_SERVE) && (|req) && !pause && !seed_load;

    assign w_ptr_d = (w_idx == C_LAST_IDX) ? '0 : w_idx + PW'(1);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .en       (w_grant_en),
        .gnt_next (w_gnt_next),
        .idx      (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lfsr_q  <= SEED;
            seed_q  <= LFSR_SAFE_SEED;
            gnt_q   <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            // Grant is a one-cycle pulse; rnd_data keeps its last value.
            gnt_q  <= '0;
            busy_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (seed_load) begin
                        seed_q  <= lfsr8_seed_fix(seed_val);
                        state_q <= ST_SEED;
                    end else if (pause) begin
                        state_q <= ST_HOLD;
                    end else if (|req) begin
                        state_q <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    if (seed_load) begin
                        seed_q  <= lfsr8_seed_fix(seed_val);
                        state_q <= ST_SEED;
                    end else if (pause) begin
                        state_q <= ST_HOLD;
                    end else if (!(|req)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gnt_q  <= w_gnt_next;
                        busy_q <= 1'b1;
                        rnd_q  <= lfsr_q;
                        lfsr_q <= lfsr8_next(lfsr_q);
                        cnt_q  <= cnt_q + 16'd1;
                        ptr_q  <= w_ptr_d;
                    end
                end

                ST_SEED: begin
                    lfsr_q <= seed_q;
                    // A back-to-back strobe re-captures and stays for another load.
                    if (seed_load) begin
                        seed_q <= lfsr8_seed_fix(seed_val);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    if (seed_load) begin
                        seed_q  <= lfsr8_seed_fix(seed_val);
                        state_q <= ST_SEED;
                    end else if (!pause) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rnd_data  = rnd_q;
    assign grant_cnt = cnt_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_rr_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_rr_server
//  Description : Self-checking bench for lfsr_rr_server. Directed scenarios
//                followed by a randomized run, all compared cycle by cycle
//                against a behavioural model of the server.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_rr_server;

    localparam int NREQ = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_SEED  = 2;
    localparam int M_HOLD  = 3;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [7:0]      rnd_data;
    logic            seed_load;
    logic [7:0]      seed_val;
    logic            pause;
    logic [15:0]     grant_cnt;
    logic            busy;

    lfsr_rr_server #(
        .NREQ (NREQ),
        .SEED (8'h01)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .pause     (pause),
        .grant_cnt (grant_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks = 0;
    int    passes = 0;
    int    fails  = 0;
    string phase  = "init";

    // Reference model state
    int          m_mode;
    logic [7:0]  m_q;
    logic [7:0]  m_pend;
    int          m_ptr;
    logic [15:0] m_cnt;
    logic [3:0]  m_gnt;
    logic [7:0]  m_rnd;

    logic [7:0]  rr_exp [6];
    logic [3:0]  rr_gnt [6];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // LFSR as arithmetic: feedback is the parity of taps 0x1D, entering at bit 7.
    function automatic logic [7:0] model_next(input logic [7:0] v);
        logic fb;
        fb = ^(v & 8'h1D);
        return (v >> 1) | (fb ? 8'h80 : 8'h00);
    endfunction

    function automatic logic [7:0] model_fix(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q    = 8'h01;
        m_pend = 8'h01;
        m_ptr  = 0;
        m_cnt  = 16'h0;
        m_gnt  = 4'h0;
        m_rnd  = 8'h00;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int   pick;
        m_gnt = 4'h0;
        pick  = -1;
        if (seed_load && m_mode != M_SEED) begin
            m_pend = model_fix(seed_val);
            m_mode = M_SEED;
        end else begin
            case (m_mode)
                M_IDLE:  if (pause) m_mode = M_HOLD; else if (req != 0) m_mode = M_SERVE;
                M_SERVE: begin
                    if (pause) m_mode = M_HOLD;
                    else if (req == 0) m_mode = M_IDLE;
                    else begin
                        for (int k = 0; k < NREQ; k++) begin
                            if (pick < 0 && req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
                        end
                    end
                end
                M_SEED: begin
                    m_q = m_pend;
                    if (seed_load) m_pend = model_fix(seed_val);
                    else m_mode = M_IDLE;
                end
                default: if (!pause) m_mode = M_IDLE;
            endcase
        end
        if (pick >= 0) begin
            m_gnt = 4'(1 << pick);
            m_rnd = m_q;
            m_q   = model_next(m_q);
            m_cnt = m_cnt + 16'd1;
            m_ptr = (pick + 1) % NREQ;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt",       16'(gnt),      16'(m_gnt));
        chk("rnd_data",  16'(rnd_data), 16'(m_rnd));
        chk("grant_cnt", grant_cnt,     m_cnt);
        chk("busy",      16'(busy),     16'(m_gnt != 4'h0));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_gnt"},  16'(gnt),      16'h0);
        chk({tag, "_rnd"},  16'(rnd_data), 16'h0);
        chk({tag, "_cnt"},  grant_cnt,     16'h0);
        chk({tag, "_busy"}, 16'(busy),     16'h0);
    endtask

    // Called at posedge+1; asserts reset between edges and releases after one edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk_cleared("rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rr_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst_n     = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_val  = 8'h00;
        pause     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        chk_cleared("por");
        rst_n = 1'b1;

        // Single requester: one idle cycle, then five back-to-back grants.
        phase = "single";
        req = 4'b0001;
        repeat (6) step();
        chk("single_cnt",  grant_cnt,      16'd5);
        chk("single_last", 16'(rnd_data),  16'h10);
        req = 4'b0000;
        step();

        // Round robin over all four requesters from a fresh reset.
        phase = "rr";
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gnt_const", 16'(gnt),      16'(rr_gnt[k]));
            chk("rr_rnd_const", 16'(rnd_data), 16'(rr_exp[k]));
        end
        req = 4'b0000;
        step();

        // Zero seed is replaced by 01.
        phase = "seed0";
        seed_load = 1'b1; seed_val = 8'h00;
        step();
        seed_load = 1'b0; req = 4'b0001;
        repeat (3) step();
        chk("seed0_rnd", 16'(rnd_data), 16'h01);
        req = 4'b0000;
        step();

        // Seed strobe together with a request: grants start three edges later.
        phase = "seedreq";
        seed_load = 1'b1; seed_val = 8'h10; req = 4'b0001;
        step();
        seed_load = 1'b0; seed_val = 8'hA5;
        repeat (2) step();
        chk("seedreq_nogrant", 16'(gnt), 16'h0);
        step();
        chk("seedreq_first", 16'(rnd_data), 16'h10);
        step();
        chk("seedreq_second", 16'(rnd_data), 16'h88);
        req = 4'b0000;
        step();

        // Pause while streaming, then release.
        phase = "pause";
        req = 4'b1111;
        repeat (4) step();
        pause = 1'b1;
        repeat (4) step();
        chk("pause_gnt", 16'(gnt), 16'h0);
        pause = 1'b0;
        repeat (5) step();

        // Asynchronous reset between edges while a grant is showing.
        phase = "midreset";
        chk("midreset_busy_pre", 16'(busy), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("async");
        model_reset();
        #2;
        rst_n = 1'b1;
        repeat (2) step();
        chk("midreset_gnt", 16'(gnt),      16'h1);
        chk("midreset_rnd", 16'(rnd_data), 16'h01);

        // Randomized run with occasional seeds (some zero) and pauses.
        phase = "random";
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(2, 0) == 0) req = 4'($urandom);
            seed_load = ($urandom_range(11, 0) == 0);
            seed_val  = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(9, 0) == 0) pause = ~pause;
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
